axi_sram_slave: RTL and testbench
=================================

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 Parameter MEM_WORDS, default 4096: number of 32-bit words in the backing store, index = addr[log2(MEM_WORDS)+1:2].
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0; addresses outside [BASE_ADDR, BASE_ADDR+4*MEM_WORDS) are out of range.
REQ-003 Parameter READ_DELAY, default 4: wait cycles, used only under REQ-031.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 AR inputs: arid 4, araddr 32, arlen 8, arsize 3, arburst 2, arvalid 1; output arready 1.
REQ-007 R outputs: rid 4, rdata 32, rresp 2, rlast 1, rvalid 1; input rready 1.
REQ-008 AW inputs: awid 4, awaddr 32, awlen 8, awsize 3, awburst 2, awvalid 1; output awready 1.
REQ-009 W inputs: wdata 32, wstrb 4, wlast 1, wvalid 1; output wready 1.
REQ-010 B outputs: bid 4, bresp 2, bvalid 1; input bready 1.
REQ-011 No lock/cache/prot/wid ports; the initiator ties those off.

Function
REQ-012 Read FSM states R_IDLE, R_WAIT, R_BURST; arready=1 only in R_IDLE.
REQ-013 AR handshake (arvalid&arready) latches arid, araddr, arlen, arsize, arburst and clears the beat counter; next state R_BURST (R_WAIT per REQ-031).
REQ-014 R_BURST: rvalid=1, rid=latched id, rdata=full aligned word at current address (narrow reads return the whole word), rlast=(beat==arlen).
REQ-015 rvalid, rdata, rresp, rlast hold stable until rready; each rvalid&rready advances the beat; rready&rlast returns to R_IDLE.
REQ-016 Address step per beat: +(1<<size) for INCR (2'b01); none for FIXED (2'b00); WRAP/reserved treated as INCR.
REQ-017 Out-of-range read beat: rresp=2'b10 SLVERR, rdata=0; in range: rresp=2'b00.
REQ-018 Write FSM states W_IDLE, W_DATA, W_RESP; awready=1 only in W_IDLE, wready=1 only in W_DATA.
REQ-019 AW handshake latches awid, awaddr, awlen, awsize, awburst; next W_DATA.
REQ-020 Each wvalid&wready beat writes wdata bytes where wstrb[i]=1 at the clock edge, then steps address per REQ-016; out-of-range beats are dropped and set a sticky error.
REQ-021 Beat counter is authoritative: beat==awlen ends data phase -> W_RESP; wlast not matching (beat==awlen) sets the sticky error.
REQ-022 W_RESP: bvalid=1, bid=latched awid, bresp=SLVERR if sticky error else OKAY; bready returns to W_IDLE and clears the error.
REQ-023 Read and write FSMs independent and concurrent; same-word read and write in one cycle returns pre-write data.
REQ-024 Max burst 256 beats (8-bit len); the 16-beat line fill/writeback (len 15, size 3'b010, INCR) is the primary use.

Reset
REQ-025 After a clock edge with rst=1: R_IDLE, W_IDLE, arready=1, awready=1, wready=0, rvalid=0, rlast=0, bvalid=0, rdata=0, rresp=0, bresp=0, rid=0, bid=0, counters 0.
REQ-026 rst mid-burst abandons the transaction with no further beats or B response; memory contents are kept, not cleared.

Configuration
REQ-031 AXI_SRAM_READ_DELAY_EN defined: after AR handshake, READ_DELAY cycles in R_WAIT (rvalid=0, arready=0) before the first beat only.
REQ-032 Not defined: R_WAIT is absent; first rvalid in the cycle after AR handshake.

Structure
REQ-033 Shared package sirius_axi_pkg: burst enum (FIXED/INCR/WRAP), resp constants (OKAY 2'b00, SLVERR 2'b10), size constant SIZE_WORD=3'b010.
REQ-034 Sub-module axi_sram_mem: MEM_WORDS x 32 array, one async read port, one byte-enabled synchronous write port.

Verification
REQ-035 AW 0x100 len 15 INCR, 16 beats data=i, wstrb=F -> one B bid=awid, bresp=OKAY; AR 0x100 len 15 -> 16 beats data 0..15, rlast only on beat 16.
REQ-036 AR 0x104 len 0 size 3'b000 after writing 0xA5A5A5A5 -> one beat rdata=0xA5A5A5A5, rlast=1, rresp=OKAY.
REQ-037 rready toggled 1/0 per cycle on 4-beat read -> rdata/rlast stable while stalled, 4 beats in order.
REQ-038 Write wstrb=4'b0010 data 0x0000_CD00 over 0x11223344 -> readback 0x1122CD44; write with wlast on beat 2 of len 3 -> bresp=SLVERR.
REQ-039 AR at BASE_ADDR+4*MEM_WORDS -> rresp=SLVERR, rdata=0; rst asserted on beat 5 of 16 -> rvalid=0 next cycle, arready=1, memory intact.
REQ-040 With AXI_SRAM_READ_DELAY_EN, READ_DELAY=4 -> first rvalid exactly 5 cycles after AR handshake; without -> 1 cycle.

Source files
------------

// File: rtl/sirius_axi_pkg.sv
// Shared AXI definitions for the SRAM slave: burst/response encodings,
// FSM state types and the per-beat address helpers.
package sirius_axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] SIZE_WORD   = 3'b010;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP}  w_state_e;

  // WRAP and the reserved encoding step like INCR; only FIXED holds the address.
  function automatic logic [31:0] next_beat_addr(input logic [31:0] addr,
                                                 input logic [2:0]  size,
                                                 input logic [1:0]  burst);
    if (burst == BURST_FIXED) return addr;
    return addr + (32'd1 << size);
  endfunction

  // 34-bit arithmetic so a window ending at 4 GiB cannot wrap.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [33:0] span);
    logic [33:0] a;
    logic [33:0] b;
    a = {2'b00, addr};
    b = {2'b00, base};
    return (a >= b) && (a < b + span);
  endfunction

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI4 read/write channel bundle for the SRAM slave (no lock/cache/prot/wid).
interface axi_sram_slave_if;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready
  );

endinterface

// File: rtl/axi_sram_mem.sv
// MEM_WORDS x 32 backing store: one asynchronous read port and one
// byte-enabled synchronous write port.
module axi_sram_mem #(
  parameter  int MEM_WORDS = 4096,
  localparam int ADDR_W    = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [3:0]        wbe,
  input  logic [31:0]       wdata
);

  logic [31:0] mem [MEM_WORDS];

  // NOTE: the array is deliberately not reset -- contents must survive rst,
  // and a reset port would stop the array mapping onto an SRAM macro.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 SRAM slave with independent read and write FSMs.
// Optional feature: define AXI_SRAM_READ_DELAY_EN to insert READ_DELAY wait cycles before each read burst.
module axi_sram_slave
  import sirius_axi_pkg::*;
#(
  parameter int          MEM_WORDS  = 4096,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          READ_DELAY = 4
) (
  input logic              clk,
  input logic              rst,
  axi_sram_slave_if.slave  bus
);

  localparam int          ADDR_W    = $clog2(MEM_WORDS);
  localparam logic [33:0] SPAN      = 34'(MEM_WORDS) * 34'd4;
  localparam logic [15:0] WAIT_LAST = 16'((READ_DELAY > 0) ? READ_DELAY - 1 : 0);
`ifdef AXI_SRAM_READ_DELAY_EN
  localparam bit          USE_WAIT  = (READ_DELAY > 0);
`else
  localparam bit          USE_WAIT  = 1'b0;
`endif

  // ---------------------------------------------------------------- read side
  r_state_e    r_state, r_state_nxt;
  logic [3:0]  r_id;
  logic [31:0] r_addr;
  logic [7:0]  r_len, r_beat;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  logic [15:0] wait_cnt;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic        rlast_q;

  logic        ar_hs, r_load, r_adv, r_done;
  logic [31:0] rd_addr, mem_rdata;
  logic        rd_ok;
  logic [7:0]  load_beat, load_len;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    r_state_nxt = r_state;
    ar_hs       = 1'b0;
    r_load      = 1'b0;
    r_adv       = 1'b0;
    r_done      = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (bus.arvalid) begin
          ar_hs = 1'b1;
          if (USE_WAIT) begin
            r_state_nxt = R_WAIT;
          end else begin
            r_state_nxt = R_BURST;
            r_load      = 1'b1;
          end
        end
      end
      R_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          r_state_nxt = R_BURST;
          r_load      = 1'b1;
        end
      end
      R_BURST: begin
        if (bus.rready) begin
          if (rlast_q) begin
            r_state_nxt = R_IDLE;
            r_done      = 1'b1;
          end else begin
            r_adv  = 1'b1;
            r_load = 1'b1;
          end
        end
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // The single read port serves whichever word is loaded next into rdata_q.
  always_comb begin
    rd_addr = bus.araddr;
    case (r_state)
      R_WAIT:  rd_addr = r_addr;
      R_BURST: rd_addr = next_beat_addr(r_addr, r_size, r_burst);
      default: rd_addr = bus.araddr;
    endcase
  end

  assign rd_ok     = in_window(rd_addr, BASE_ADDR, SPAN);
  assign load_beat = r_adv ? (r_beat + 8'd1) : 8'd0;
  assign load_len  = (r_state == R_IDLE) ? bus.arlen : r_len;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
    end else begin
      r_state <= r_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_id     <= '0;
      r_addr   <= '0;
      r_len    <= '0;
      r_size   <= '0;
      r_burst  <= '0;
      r_beat   <= '0;
      wait_cnt <= '0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      rlast_q  <= 1'b0;
    end else begin
      if (ar_hs) begin
        r_id     <= bus.arid;
        r_addr   <= bus.araddr;
        r_len    <= bus.arlen;
        r_size   <= bus.arsize;
        r_burst  <= bus.arburst;
        r_beat   <= '0;
        wait_cnt <= '0;
      end
      if (r_state == R_WAIT) wait_cnt <= wait_cnt + 16'd1;
      if (r_adv) begin
        r_addr <= next_beat_addr(r_addr, r_size, r_burst);
        r_beat <= r_beat + 8'd1;
      end
      if (r_load) begin
        rdata_q <= rd_ok ? mem_rdata : 32'd0;
        rresp_q <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        rlast_q <= (load_beat == load_len);
      end
      if (r_done) rlast_q <= 1'b0;
    end
  end

  assign bus.arready = (r_state == R_IDLE);
  assign bus.rvalid  = (r_state == R_BURST);
  assign bus.rid     = r_id;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign bus.rlast   = rlast_q;

  // --------------------------------------------------------------- write side
  w_state_e    w_state, w_state_nxt;
  logic [3:0]  w_id;
  logic [31:0] w_addr;
  logic [7:0]  w_len, w_beat;
  logic [2:0]  w_size;
  logic [1:0]  w_burst;
  logic        w_err;
  logic        aw_hs, w_hs, b_hs, wr_ok, w_final;

  assign w_final = (w_beat == w_len);
  assign wr_ok   = in_window(w_addr, BASE_ADDR, SPAN);

  always_comb begin
    w_state_nxt = w_state;
    aw_hs       = 1'b0;
    w_hs        = 1'b0;
    b_hs        = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (bus.awvalid) begin
          aw_hs       = 1'b1;
          w_state_nxt = W_DATA;
        end
      end
      W_DATA: begin
        if (bus.wvalid) begin
          w_hs = 1'b1;
          if (w_final) w_state_nxt = W_RESP;
        end
      end
      W_RESP: begin
        if (bus.bready) begin
          b_hs        = 1'b1;
          w_state_nxt = W_IDLE;
        end
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
    end else begin
      w_state <= w_state_nxt;
    end
  end

  // The beat counter, not wlast, decides where the burst ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_beat  <= '0;
      w_err   <= 1'b0;
    end else begin
      if (aw_hs) begin
        w_id    <= bus.awid;
        w_addr  <= bus.awaddr;
        w_len   <= bus.awlen;
        w_size  <= bus.awsize;
        w_burst <= bus.awburst;
        w_beat  <= '0;
      end
      if (w_hs) begin
        w_addr <= next_beat_addr(w_addr, w_size, w_burst);
        w_beat <= w_beat + 8'd1;
        if (!wr_ok || (bus.wlast != w_final)) w_err <= 1'b1;
      end
      if (b_hs) w_err <= 1'b0;
    end
  end

  assign bus.awready = (w_state == W_IDLE);
  assign bus.wready  = (w_state == W_DATA);
  assign bus.bvalid  = (w_state == W_RESP);
  assign bus.bid     = w_id;
  assign bus.bresp   = ((w_state == W_RESP) && w_err) ? RESP_SLVERR : RESP_OKAY;

  // ------------------------------------------------------------------ storage
  axi_sram_mem #(.MEM_WORDS(MEM_WORDS)) u_mem (
    .clk   (clk),
    .raddr (rd_addr[ADDR_W+1:2]),
    .rdata (mem_rdata),
    .we    (w_hs && wr_ok),
    .waddr (w_addr[ADDR_W+1:2]),
    .wbe   (bus.wstrb),
    .wdata (bus.wdata)
  );

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: a vector table of single transactions
// plus hand-written sequences for stalls, latency, same-cycle access and reset.
module tb_axi_sram_slave;
  import sirius_axi_pkg::*;

  localparam int          MEM_WORDS  = 4096;
  localparam logic [31:0] BASE       = 32'h0000_0000;
  localparam int          READ_DELAY = 4;
`ifdef AXI_SRAM_READ_DELAY_EN
  localparam int          EXP_LAT    = READ_DELAY + 1;
  localparam logic [31:0] EXP_CONC   = 32'h5555_FFFF;
`else
  localparam int          EXP_LAT    = 1;
  localparam logic [31:0] EXP_CONC   = 32'hAAAA_0000;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_sram_slave_if bus ();

  axi_sram_slave #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE), .READ_DELAY(READ_DELAY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  logic [31:0] rd_data [256];
  logic [1:0]  rd_resp [256];
  logic        rd_last [256];
  logic [3:0]  rd_id   [256];
  int          rd_lat;
  int          rd_beats;

  task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    bit ok = 0;
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
    bus.arvalid = 1'b1;
    for (int c = 0; c < 50 && !ok; c++) begin
      if (bus.arready) ok = 1;
      else begin @(posedge clk); #1; end
    end
    if (ok) begin @(posedge clk); #1; end
    bus.arvalid = 1'b0;
    check("ar_handshake", 32'(ok), 32'd1);
  endtask

  task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    bit ok = 0;
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
    bus.awvalid = 1'b1;
    for (int c = 0; c < 50 && !ok; c++) begin
      if (bus.awready) ok = 1;
      else begin @(posedge clk); #1; end
    end
    if (ok) begin @(posedge clk); #1; end
    bus.awvalid = 1'b0;
    check("aw_handshake", 32'(ok), 32'd1);
  endtask

  task automatic w_send(input logic [31:0] data0, input logic [31:0] inc, input logic [3:0] strb,
                        input int len, input int wlast_at);
    for (int b = 0; b <= len; b++) begin
      bit ok = 0;
      bus.wdata = data0 + inc * 32'(b); bus.wstrb = strb;
      bus.wlast = (b == wlast_at); bus.wvalid = 1'b1;
      for (int c = 0; c < 50 && !ok; c++) begin
        if (bus.wready) ok = 1;
        else begin @(posedge clk); #1; end
      end
      if (!ok) begin
        check("w_handshake", 32'(ok), 32'd1);
        bus.wvalid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
  endtask

  task automatic b_collect(output logic [3:0] id, output logic [1:0] resp);
    bit ok = 0;
    id = 'x; resp = 'x;
    bus.bready = 1'b1;
    for (int c = 0; c < 50 && !ok; c++) begin
      if (bus.bvalid) begin ok = 1; id = bus.bid; resp = bus.bresp; end
      else begin @(posedge clk); #1; end
    end
    if (ok) begin @(posedge clk); #1; end
    bus.bready = 1'b0;
    check("b_handshake", 32'(ok), 32'd1);
  endtask

  // Collects len+1 beats; toggle alternates rready, abort_at pulses rst when that beat shows.
  task automatic rd_collect(input int len, input bit toggle, input int abort_at);
    bit          have_snap = 0;
    logic [31:0] snap_d;
    logic        snap_l;
    int          beat = 0;
    int          cyc = 0;
    rd_lat = 0;
    bus.rready = toggle ? 1'b0 : 1'b1;
    while (beat <= len && cyc < 600) begin
      if (bus.rvalid && rd_lat == 0) rd_lat = cyc + 1;
      if (bus.rvalid && beat == abort_at) begin
        rst = 1'b1; bus.rready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        rd_beats = beat;
        return;
      end
      if (bus.rvalid && bus.rready) begin
        if (have_snap) begin
          check("stall_rdata", bus.rdata, snap_d);
          check("stall_rlast", 32'(bus.rlast), 32'(snap_l));
          have_snap = 0;
        end
        rd_data[beat] = bus.rdata; rd_resp[beat] = bus.rresp;
        rd_last[beat] = bus.rlast; rd_id[beat]   = bus.rid;
        beat++;
      end else if (bus.rvalid) begin
        snap_d = bus.rdata; snap_l = bus.rlast; have_snap = 1;
      end
      @(posedge clk); #1;
      cyc++;
      if (toggle) bus.rready = ~bus.rready;
    end
    bus.rready = 1'b0;
    rd_beats = beat;
    check("rd_complete", 32'(beat), 32'(len + 1));
  endtask

  typedef struct {
    bit          is_wr;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [31:0] data;      // write: first data; read: expected first data
    logic [31:0] inc;       // per-beat data increment
    logic [3:0]  strb;
    int          wlast_at;
    logic [1:0]  exp_resp;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  logic [3:0] b_id;
  logic [1:0] b_resp;

  initial begin
    vecs[0]  = '{1'b1, 4'h3, 32'h100,  8'd15, SIZE_WORD, BURST_INCR,  32'h0,         32'h1, 4'hF, 15, RESP_OKAY};
    vecs[1]  = '{1'b0, 4'h5, 32'h100,  8'd15, SIZE_WORD, BURST_INCR,  32'h0,         32'h1, 4'hF, 0,  RESP_OKAY};
    vecs[2]  = '{1'b1, 4'h1, 32'h104,  8'd0,  SIZE_WORD, BURST_INCR,  32'hA5A5_A5A5, 32'h0, 4'hF, 0,  RESP_OKAY};
    vecs[3]  = '{1'b0, 4'h2, 32'h104,  8'd0,  3'b000,    BURST_INCR,  32'hA5A5_A5A5, 32'h0, 4'hF, 0,  RESP_OKAY};
    vecs[4]  = '{1'b1, 4'h4, 32'h200,  8'd0,  SIZE_WORD, BURST_INCR,  32'h1122_3344, 32'h0, 4'hF, 0,  RESP_OKAY};
    vecs[5]  = '{1'b1, 4'h4, 32'h200,  8'd0,  SIZE_WORD, BURST_INCR,  32'h0000_CD00, 32'h0, 4'b0010, 0, RESP_OKAY};
    vecs[6]  = '{1'b0, 4'h6, 32'h200,  8'd0,  SIZE_WORD, BURST_INCR,  32'h1122_CD44, 32'h0, 4'hF, 0,  RESP_OKAY};
    vecs[7]  = '{1'b1, 4'h7, 32'h400,  8'd3,  SIZE_WORD, BURST_INCR,  32'h40,        32'h1, 4'hF, 1,  RESP_SLVERR};
    vecs[8]  = '{1'b0, 4'h7, 32'h400,  8'd3,  SIZE_WORD, BURST_INCR,  32'h40,        32'h1, 4'hF, 0,  RESP_OKAY};
    vecs[9]  = '{1'b1, 4'h8, 32'h300,  8'd3,  SIZE_WORD, BURST_FIXED, 32'h10,        32'h1, 4'hF, 3,  RESP_OKAY};
    vecs[10] = '{1'b0, 4'h9, 32'h300,  8'd2,  SIZE_WORD, BURST_FIXED, 32'h13,        32'h0, 4'hF, 0,  RESP_OKAY};
    vecs[11] = '{1'b0, 4'hA, 32'h4000, 8'd0,  SIZE_WORD, BURST_INCR,  32'h0,         32'h0, 4'hF, 0,  RESP_SLVERR};
    vecs[12] = '{1'b1, 4'hB, 32'h4000, 8'd0,  SIZE_WORD, BURST_INCR,  32'hDEAD,      32'h0, 4'hF, 0,  RESP_SLVERR};
    vecs[13] = '{1'b1, 4'hC, 32'h3FFC, 8'd1,  SIZE_WORD, BURST_INCR,  32'h77,        32'h1, 4'hF, 1,  RESP_SLVERR};
    vecs[14] = '{1'b0, 4'hD, 32'h3FFC, 8'd0,  SIZE_WORD, BURST_INCR,  32'h77,        32'h0, 4'hF, 0,  RESP_OKAY};

    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.rready = 1'b0; bus.bready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_arready", 32'(bus.arready), 32'd1);
    check("rst_awready", 32'(bus.awready), 32'd1);
    check("rst_wready",  32'(bus.wready),  32'd0);
    check("rst_rvalid",  32'(bus.rvalid),  32'd0);
    check("rst_rlast",   32'(bus.rlast),   32'd0);
    check("rst_bvalid",  32'(bus.bvalid),  32'd0);
    check("rst_rdata",   bus.rdata,        32'd0);
    check("rst_rresp",   32'(bus.rresp),   32'd0);
    check("rst_bresp",   32'(bus.bresp),   32'd0);
    check("rst_rid",     32'(bus.rid),     32'd0);
    check("rst_bid",     32'(bus.bid),     32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].is_wr) begin
        aw_send(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst);
        w_send(vecs[i].data, vecs[i].inc, vecs[i].strb, int'(vecs[i].len), vecs[i].wlast_at);
        b_collect(b_id, b_resp);
        check($sformatf("v%0d_bid", i),   32'(b_id),   32'(vecs[i].id));
        check($sformatf("v%0d_bresp", i), 32'(b_resp), 32'(vecs[i].exp_resp));
      end else begin
        ar_send(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst);
        rd_collect(int'(vecs[i].len), 1'b0, -1);
        check($sformatf("v%0d_rid", i), 32'(rd_id[0]), 32'(vecs[i].id));
        for (int b = 0; b <= int'(vecs[i].len) && b < rd_beats; b++) begin
          check($sformatf("v%0d_b%0d_rdata", i, b), rd_data[b], vecs[i].data + vecs[i].inc * 32'(b));
          check($sformatf("v%0d_b%0d_rresp", i, b), 32'(rd_resp[b]), 32'(vecs[i].exp_resp));
          check($sformatf("v%0d_b%0d_rlast", i, b), 32'(rd_last[b]), 32'(b == int'(vecs[i].len)));
        end
      end
    end

    // First-beat latency after the AR handshake.
    ar_send(4'h1, 32'h108, 8'd0, SIZE_WORD, BURST_INCR);
    rd_collect(0, 1'b0, -1);
    check("first_rvalid_latency", 32'(rd_lat), 32'(EXP_LAT));
    check("latency_rdata", rd_data[0], 32'd2);

    // rready toggling on a 4-beat read: words 0x108..0x114 hold 2..5.
    ar_send(4'h2, 32'h108, 8'd3, SIZE_WORD, BURST_INCR);
    rd_collect(3, 1'b1, -1);
    for (int b = 0; b < 4 && b < rd_beats; b++) begin
      check($sformatf("toggle_b%0d_rdata", b), rd_data[b], 32'(b + 2));
      check($sformatf("toggle_b%0d_rlast", b), 32'(rd_last[b]), 32'(b == 3));
    end

    // Read and write handshake to the same word on the same edge.
    aw_send(4'h6, 32'h500, 8'd0, SIZE_WORD, BURST_INCR);
    w_send(32'hAAAA_0000, 32'h0, 4'hF, 0, 0);
    b_collect(b_id, b_resp);
    aw_send(4'h7, 32'h500, 8'd0, SIZE_WORD, BURST_INCR);
    bus.wdata = 32'h5555_FFFF; bus.wstrb = 4'hF; bus.wlast = 1'b1; bus.wvalid = 1'b1;
    bus.arid = 4'h8; bus.araddr = 32'h500; bus.arlen = 8'd0; bus.arsize = SIZE_WORD;
    bus.arburst = BURST_INCR; bus.arvalid = 1'b1;
    check("conc_both_ready", {30'd0, bus.wready, bus.arready}, 32'd3);
    @(posedge clk); #1;
    bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.arvalid = 1'b0;
    rd_collect(0, 1'b0, -1);
    check("conc_rdata", rd_data[0], EXP_CONC);
    b_collect(b_id, b_resp);
    check("conc_bresp", 32'(b_resp), 32'(RESP_OKAY));
    ar_send(4'h9, 32'h500, 8'd0, SIZE_WORD, BURST_INCR);
    rd_collect(0, 1'b0, -1);
    check("conc_reread", rd_data[0], 32'h5555_FFFF);

    // Reset while beat 5 of a 16-beat read is on the bus.
    ar_send(4'h3, 32'h100, 8'd15, SIZE_WORD, BURST_INCR);
    rd_collect(15, 1'b0, 4);
    check("abort_beats", 32'(rd_beats), 32'd4);
    check("abort_rvalid", 32'(bus.rvalid), 32'd0);
    check("abort_arready", 32'(bus.arready), 32'd1);
    bus.rready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_more_beats", 32'(bus.rvalid), 32'd0);
    bus.rready = 1'b0;
    ar_send(4'h4, 32'h10C, 8'd0, SIZE_WORD, BURST_INCR);
    rd_collect(0, 1'b0, -1);
    check("mem_kept_0x10c", rd_data[0], 32'd3);
    ar_send(4'h4, 32'h13C, 8'd0, SIZE_WORD, BURST_INCR);
    rd_collect(0, 1'b0, -1);
    check("mem_kept_0x13c", rd_data[0], 32'd15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
